// File: rtl/keypad_event_encoder.sv
// Debounced A/S/D/W keypad encoder with auto-repeat.
// Emits one character per press or repeat on a valid/ready stream.
module keypad_event_encoder #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_key_a,
    input  logic                  i_key_s,
    input  logic                  i_key_d,
    input  logic                  i_key_w,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_key_pressed,
    output logic                  o_overrun
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TMR_W-1:0] DLY_LD  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LD  = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic             RPT_ON  = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    logic [3:0]            s1_q, s1_d;
    logic [3:0]            s2_q, s2_d;
    logic [3:0]            cand_q, cand_d;
    logic [3:0]            stable_q, stable_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  chg_q, chg_d;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pressed_q, pressed_d;
    logic                  ovr_q, ovr_d;

    logic [DATA_WIDTH-1:0] code;
    logic                  code_ok;
    logic                  evt;

    // Synchroniser and debounce
    always_comb begin
        s1_d     = {i_key_a, i_key_s, i_key_d, i_key_w};
        s2_d     = s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_d    = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != DEB_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (cnt_d == DEB_MAX && cand_q != stable_q) begin
                stable_d = cand_q;
                chg_d    = 1'b1;
            end
        end
    end

    always_comb begin
        code_ok = 1'b1;
        code    = '0;
        unique case (stable_q)
            4'b1000: code = DATA_WIDTH'(8'h61);
            4'b0100: code = DATA_WIDTH'(8'h73);
            4'b0010: code = DATA_WIDTH'(8'h64);
            4'b0001: code = DATA_WIDTH'(8'h77);
            4'b1001: code = DATA_WIDTH'(8'h23);
            4'b0011: code = DATA_WIDTH'(8'h24);
            4'b1100: code = DATA_WIDTH'(8'h25);
            4'b0110: code = DATA_WIDTH'(8'h26);
            default: code_ok = 1'b0;
        endcase
    end

    // Event FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Event FSM: next state
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (chg_q) begin
            if (code_ok) begin
                state_d = DELAY;
                timer_d = DLY_LD;
            end else begin
                state_d = IDLE;
                timer_d = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    timer_d = '0;
                end
                DELAY: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TMR_ONE;
                    end else if (RPT_ON) begin
                        state_d = REPEAT;
                        timer_d = PER_LD;
                    end
                end
                REPEAT: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TMR_ONE;
                    end else begin
                        timer_d = PER_LD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Event FSM: outputs
    always_comb begin
        evt = 1'b0;
        if (chg_q) begin
            evt = code_ok;
        end else begin
            unique case (state_q)
                IDLE:    evt = 1'b0;
                DELAY:   evt = (timer_q == '0) && RPT_ON;
                REPEAT:  evt = (timer_q == '0);
                default: evt = 1'b0;
            endcase
        end
    end

    // Output register; back-pressure drops events but never stalls timing
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = 1'b0;
        pressed_d = |stable_q;
        if (evt) begin
            if (!valid_q || i_ready) begin
                data_d  = code;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            chg_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            chg_q     <= chg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_key_pressed = pressed_q;
    assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder (debounce 4, delay 20, period 5).
// A second instance with auto-repeat disabled shares all inputs.
module tb_keypad_event_encoder;

    logic       clk;
    logic       rst_n;
    logic       ka, ks, kd, kw;
    logic       ready;

    logic [7:0] data1, data2;
    logic       valid1, valid2;
    logic       kp1, kp2;
    logic       ovr1, ovr2;

    int checks;
    int failures;
    int acc1, acc2, ovc1;
    int base, base2;

    keypad_event_encoder #(
        .DATA_WIDTH(8), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_a(ka), .i_key_s(ks), .i_key_d(kd), .i_key_w(kw),
        .i_ready(ready),
        .o_data(data1), .o_valid(valid1),
        .o_key_pressed(kp1), .o_overrun(ovr1)
    );

    keypad_event_encoder #(
        .DATA_WIDTH(8), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut_nr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_a(ka), .i_key_s(ks), .i_key_d(kd), .i_key_w(kw),
        .i_ready(ready),
        .o_data(data2), .o_valid(valid2),
        .o_key_pressed(kp2), .o_overrun(ovr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (valid1 && ready) acc1 <= acc1 + 1;
        if (valid2 && ready) acc2 <= acc2 + 1;
        if (ovr1) ovc1 <= ovc1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        acc1 = 0; acc2 = 0; ovc1 = 0;
        rst_n = 1'b0; ready = 1'b1;
        ka = 1'b0; ks = 1'b0; kd = 1'b0; kw = 1'b1;

        // Reset with w held
        tick(3);
        chk("rst_data", 32'(data1), 32'h0);
        chk("rst_valid", 32'(valid1), 32'h0);
        chk("rst_kp", 32'(kp1), 32'h0);
        chk("rst_ovr", 32'(ovr1), 32'h0);
        rst_n = 1'b1;
        base = acc1;
        tick(7);
        chk("w_early", 32'(valid1), 32'h0);
        tick(1);
        chk("w_valid", 32'(valid1), 32'h1);
        chk("w_data", 32'(data1), 32'h77);
        chk("w_kp", 32'(kp1), 32'h1);
        kw = 1'b0;
        tick(30);
        chk("w_release_cnt", 32'(acc1 - base), 32'd1);
        chk("w_release_kp", 32'(kp1), 32'h0);

        // Bounce on a, then settle
        base = acc1;
        repeat (2) begin
            ka = 1'b1; tick(3);
            ka = 1'b0; tick(3);
        end
        chk("bounce_valid", 32'(valid1), 32'h0);
        chk("bounce_kp", 32'(kp1), 32'h0);
        chk("bounce_cnt", 32'(acc1 - base), 32'd0);
        ka = 1'b1;
        tick(7);
        chk("a_early", 32'(valid1), 32'h0);
        tick(1);
        chk("a_valid", 32'(valid1), 32'h1);
        chk("a_data", 32'(data1), 32'h61);
        ka = 1'b0;
        tick(30);
        chk("a_cnt", 32'(acc1 - base), 32'd1);

        // Hold s: auto-repeat at T, T+20, T+25, T+30, T+35
        base = acc1; base2 = acc2;
        ks = 1'b1;
        tick(8);
        chk("s_first", 32'(valid1), 32'h1);
        chk("s_data", 32'(data1), 32'h73);
        chk("s_nr_first", 32'(valid2), 32'h1);
        tick(19);
        chk("s_pre_rep", 32'(valid1), 32'h0);
        tick(1);
        chk("s_rep20", 32'(valid1), 32'h1);
        chk("s_rep20_data", 32'(data1), 32'h73);
        tick(5);
        chk("s_rep25", 32'(valid1), 32'h1);
        tick(5);
        chk("s_rep30", 32'(valid1), 32'h1);
        ks = 1'b0;
        tick(5);
        chk("s_rep35", 32'(valid1), 32'h1);
        tick(30);
        chk("s_total", 32'(acc1 - base), 32'd5);
        chk("s_nr_total", 32'(acc2 - base2), 32'd1);

        // Combo: w, then add a
        base = acc1;
        kw = 1'b1;
        tick(8);
        chk("cw_valid", 32'(valid1), 32'h1);
        chk("cw_data", 32'(data1), 32'h77);
        tick(3);
        ka = 1'b1;
        tick(7);
        chk("combo_early", 32'(valid1), 32'h0);
        tick(1);
        chk("combo_valid", 32'(valid1), 32'h1);
        chk("combo_data", 32'(data1), 32'h23);
        kw = 1'b0; ks = 1'b1; kd = 1'b1;
        tick(10);
        chk("asd_valid", 32'(valid1), 32'h0);
        chk("asd_kp", 32'(kp1), 32'h1);
        chk("asd_data_hold", 32'(data1), 32'h23);
        chk("asd_cnt", 32'(acc1 - base), 32'd2);
        ka = 1'b0; ks = 1'b0; kd = 1'b0;
        tick(12);
        chk("asd_release_kp", 32'(kp1), 32'h0);

        // Back-pressure during repeats
        ready = 1'b0;
        base = ovc1;
        ks = 1'b1;
        tick(8);
        chk("bp_first", 32'(valid1), 32'h1);
        tick(19);
        chk("bp_pre_ovr", 32'(ovr1), 32'h0);
        tick(1);
        chk("bp_ovr20", 32'(ovr1), 32'h1);
        chk("bp_hold_valid", 32'(valid1), 32'h1);
        chk("bp_hold_data", 32'(data1), 32'h73);
        tick(1);
        chk("bp_ovr_pulse", 32'(ovr1), 32'h0);
        tick(8);
        ready = 1'b1;
        tick(1);
        chk("bp_accept_load", 32'(valid1), 32'h1);
        chk("bp_accept_ovr", 32'(ovr1), 32'h0);
        tick(1);
        chk("bp_clear", 32'(valid1), 32'h0);
        chk("bp_ovr_total", 32'(ovc1 - base), 32'd2);
        ks = 1'b0;
        tick(15);

        // Asynchronous reset mid-DELAY with o_valid high
        ready = 1'b0;
        kd = 1'b1;
        tick(8);
        chk("d_valid", 32'(valid1), 32'h1);
        chk("d_data", 32'(data1), 32'h64);
        tick(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid1), 32'h0);
        chk("arst_data", 32'(data1), 32'h0);
        chk("arst_kp", 32'(kp1), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(7);
        chk("redet_early", 32'(valid1), 32'h0);
        tick(1);
        chk("redet_valid", 32'(valid1), 32'h1);
        chk("redet_data", 32'(data1), 32'h64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
